// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: one data-memory transaction at a time over req/gnt/rvalid
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      operation handshake from the execute stage
//   req_load/req_store       operation kind (mutually exclusive)
//   req_funct3               RV32I load/store width/sign encoding
//   req_addr, req_wdata      effective address and store data
//   req_rd                   load destination register
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata   bus request (word address, lane enables)
//   mem_gnt, mem_rvalid, mem_rdata             bus grant and read return
//   resp_valid               one-cycle completion pulse
//   resp_rdata, resp_rd      extended load data and destination (0 for stores)
//   resp_misaligned          alignment fault
//   resp_fault               illegal funct3 or bus timeout
//   busy                     transaction in flight
module lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_misaligned,
    output logic        resp_fault,
    output logic        busy
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t        state;
    logic [CW-1:0] tcnt;
    logic [2:0]    op_funct3;
    logic [1:0]    op_off;
    logic          op_store;
    logic [4:0]    op_rd;

    logic        accept;
    logic        illegal_f3;
    logic        misaligned;
    logic [3:0]  be_base;
    logic [31:0] wdata_lanes;
    logic [31:0] shifted;
    logic [31:0] load_ext;
    logic        timeout_hit;

    assign accept = req_valid & req_ready & (req_load | req_store);

    // Loads accept 000/001/010/100/101; stores only 000/001/010.
    assign illegal_f3 = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11)
                      | (req_store & req_funct3[2]);

    assign misaligned = ((req_funct3[1:0] == 2'b01) & req_addr[0])
                      | ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));

    always_comb begin
        be_base     = 4'b1111;
        wdata_lanes = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                be_base     = 4'b0001;
                wdata_lanes = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_base     = 4'b0011;
                wdata_lanes = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign shifted = mem_rdata >> {op_off, 3'b000};

    always_comb begin
        load_ext = shifted;
        case (op_funct3)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'h0, shifted[7:0]};
            3'b101:  load_ext = {16'h0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    // The budget spans REQ and WAIT together, so a grant that lands on the
    // last counted cycle leaves no WAIT cycles; >= covers that overshoot.
    assign timeout_hit = (tcnt >= CW'(TIMEOUT_CYCLES - 1));

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            tcnt            <= '0;
            op_funct3       <= '0;
            op_off          <= '0;
            op_store        <= 1'b0;
            op_rd           <= '0;
            req_ready       <= 1'b1;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_be          <= '0;
            mem_wdata       <= '0;
            resp_valid      <= 1'b0;
            resp_rdata      <= '0;
            resp_rd         <= '0;
            resp_misaligned <= 1'b0;
            resp_fault      <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        tcnt      <= '0;
                        op_funct3 <= req_funct3;
                        op_off    <= req_addr[1:0];
                        op_store  <= req_store;
                        op_rd     <= req_rd;
                        if (illegal_f3 || misaligned) begin
                            state           <= DONE;
                            resp_valid      <= 1'b1;
                            resp_rdata      <= '0;
                            resp_rd         <= req_store ? 5'd0 : req_rd;
                            resp_fault      <= illegal_f3;
                            resp_misaligned <= ~illegal_f3;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= req_store;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= be_base << req_addr[1:0];
                            mem_wdata <= req_store ? wdata_lanes : 32'h0;
                        end
                    end
                end
                REQ: begin
                    tcnt <= tcnt + 1'b1;
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (op_store) begin
                            state           <= DONE;
                            resp_valid      <= 1'b1;
                            resp_rdata      <= '0;
                            resp_rd         <= '0;
                            resp_fault      <= 1'b0;
                            resp_misaligned <= 1'b0;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (timeout_hit) begin
                        mem_req         <= 1'b0;
                        state           <= DONE;
                        resp_valid      <= 1'b1;
                        resp_rdata      <= '0;
                        resp_rd         <= op_store ? 5'd0 : op_rd;
                        resp_fault      <= 1'b1;
                        resp_misaligned <= 1'b0;
                    end
                end
                WAIT: begin
                    tcnt <= tcnt + 1'b1;
                    if (mem_rvalid) begin
                        state           <= DONE;
                        resp_valid      <= 1'b1;
                        resp_rdata      <= load_ext;
                        resp_rd         <= op_rd;
                        resp_fault      <= 1'b0;
                        resp_misaligned <= 1'b0;
                    end else if (timeout_hit) begin
                        state           <= DONE;
                        resp_valid      <= 1'b1;
                        resp_rdata      <= '0;
                        resp_rd         <= op_rd;
                        resp_fault      <= 1'b1;
                        resp_misaligned <= 1'b0;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - scoreboard bench for lsu
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_load, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_misaligned, resp_fault, busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        mis;
        logic        flt;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
        .resp_misaligned(resp_misaligned), .resp_fault(resp_fault),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Scoreboard: every response pulse must match the oldest pushed expectation.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_rd", {27'd0, resp_rd}, {27'd0, e.rd});
                chk("resp_misaligned", {31'd0, resp_misaligned}, {31'd0, e.mis});
                chk("resp_fault", {31'd0, resp_fault}, {31'd0, e.flt});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
        req_valid  = 1'b1;
        req_load   = ld;
        req_store  = ~ld;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        tick();
        req_valid  = 1'b0;
        req_load   = 1'b0;
        req_store  = 1'b0;
    endtask

    task automatic run_op(input string name, input logic ld, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, input int gnt_delay,
                          input logic [31:0] rdata, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_rdata);
        exp_t e;
        e.rdata = exp_rdata;
        e.rd    = ld ? rd : 5'd0;
        e.mis   = 1'b0;
        e.flt   = 1'b0;
        sb.push_back(e);
        drive(ld, f3, addr, wdata, rd);
        for (int i = 0; i <= gnt_delay; i++) begin
            chk({name, "_mem_req"}, {31'd0, mem_req}, 32'd1);
            chk({name, "_mem_we"}, {31'd0, mem_we}, {31'd0, ~ld});
            chk({name, "_mem_addr"}, mem_addr, exp_addr);
            chk({name, "_mem_be"}, {28'd0, mem_be}, {28'd0, exp_be});
            chk({name, "_mem_wdata"}, mem_wdata, exp_wdata);
            chk({name, "_ready"}, {31'd0, req_ready}, 32'd0);
            if (i == gnt_delay) begin
                mem_gnt = 1'b1;
                // Returned data in the grant cycle must be ignored.
                if (ld) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = 32'hDEAD_BEEF;
                end
            end
            tick();
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        if (ld) begin
            chk({name, "_req_drop"}, {31'd0, mem_req}, 32'd0);
            chk({name, "_wait_noresp"}, {31'd0, resp_valid}, 32'd0);
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            tick();
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
        end
        chk({name, "_resp_lat"}, {31'd0, resp_valid}, 32'd1);
        chk({name, "_busy_done"}, {31'd0, busy}, 32'd1);
        tick();
        chk({name, "_resp_pulse"}, {31'd0, resp_valid}, 32'd0);
        chk({name, "_ready_back"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic fault_op(input string name, input logic ld, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [4:0] rd,
                            input logic exp_mis, input logic exp_flt);
        exp_t e;
        e.rdata = 32'h0;
        e.rd    = ld ? rd : 5'd0;
        e.mis   = exp_mis;
        e.flt   = exp_flt;
        sb.push_back(e);
        drive(ld, f3, addr, 32'hFFFF_FFFF, rd);
        chk({name, "_resp_lat"}, {31'd0, resp_valid}, 32'd1);
        chk({name, "_no_bus"}, {31'd0, mem_req}, 32'd0);
        tick();
        chk({name, "_ready_back"}, {31'd0, req_ready}, 32'd1);
        chk({name, "_no_bus2"}, {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_load   = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_rd     = 5'd0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_be", {28'd0, mem_be}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Stray req_valid with neither load nor store must be ignored.
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("nop_ignored", {31'd0, busy}, 32'd0);

        //     name   ld  f3      addr          wdata         rd  gd rdata          addr          be       wdata         result
        run_op("lb",  1, 3'b000, 32'h0000_0103, 32'h0,        5,  0, 32'h8000_0000, 32'h0000_0100, 4'b1000, 32'h0,        32'hFFFF_FF80);
        run_op("lhu", 1, 3'b101, 32'h0000_0102, 32'h0,        6,  0, 32'hBEEF_1234, 32'h0000_0100, 4'b1100, 32'h0,        32'h0000_BEEF);
        run_op("lh",  1, 3'b001, 32'h0000_0102, 32'h0,        7,  1, 32'hBEEF_1234, 32'h0000_0100, 4'b1100, 32'h0,        32'hFFFF_BEEF);
        run_op("lbu", 1, 3'b100, 32'h0000_0101, 32'h0,        8,  0, 32'h0000_8100, 32'h0000_0100, 4'b0010, 32'h0,        32'h0000_0081);
        run_op("lw",  1, 3'b010, 32'h0000_0004, 32'h0,        9,  2, 32'h89AB_CDEF, 32'h0000_0004, 4'b1111, 32'h0,        32'h89AB_CDEF);
        run_op("sh",  0, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 10, 3, 32'h0,        32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'h0);
        run_op("sb",  0, 3'b000, 32'h0000_0001, 32'h7766_55A5, 11, 0, 32'h0,        32'h0000_0000, 4'b0010, 32'hA5A5_A5A5, 32'h0);
        run_op("sw",  0, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 12, 1, 32'h0,        32'h0000_0300, 4'b1111, 32'hCAFE_F00D, 32'h0);

        //       name        ld  f3      addr          rd  mis flt
        fault_op("lw_mis",   1, 3'b010, 32'h0000_0105, 13, 1, 0);
        fault_op("f3_011",   1, 3'b011, 32'h0000_0100, 14, 0, 1);
        fault_op("lh_mis",   1, 3'b001, 32'h0000_0101, 15, 1, 0);
        fault_op("lhu_mis",  1, 3'b101, 32'h0000_0103, 16, 1, 0);
        fault_op("sb_f3_4",  0, 3'b100, 32'h0000_0100, 17, 0, 1);
        fault_op("f3_111p",  1, 3'b111, 32'h0000_0101, 18, 0, 1);

        // Timeout: grant never arrives.
        begin
            exp_t e;
            e.rdata = 32'h0;
            e.rd    = 5'd19;
            e.mis   = 1'b0;
            e.flt   = 1'b1;
            sb.push_back(e);
        end
        drive(1'b1, 3'b010, 32'h0000_0040, 32'h0, 5'd19);
        for (int i = 0; i < 4; i++) begin
            chk("to_mem_req", {31'd0, mem_req}, 32'd1);
            chk("to_no_resp", {31'd0, resp_valid}, 32'd0);
            tick();
        end
        chk("to_resp", {31'd0, resp_valid}, 32'd1);
        chk("to_req_drop", {31'd0, mem_req}, 32'd0);
        tick();
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_1111;
        tick();
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        chk("stray_busy", {31'd0, busy}, 32'd0);
        tick();

        // Reset while waiting for read data: no response for the aborted load.
        drive(1'b1, 3'b010, 32'h0000_0010, 32'h0, 5'd20);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("wait_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_resp", {31'd0, resp_valid}, 32'd0);
        chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        tick();
        rst = 1'b0;
        tick();
        run_op("lw0", 1, 3'b010, 32'h0000_0000, 32'h0, 21, 0, 32'h0BAD_F00D, 32'h0, 4'b1111, 32'h0, 32'h0BAD_F00D);

        tick();
        tick();
        chk("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit sitting directly downstream of the ALU in the execute path.
- Takes the ALU-computed effective address plus store data and funct3, and runs one data-memory transaction over a request/grant/rvalid bus.
- Returns aligned, sign- or zero-extended load data, or a fault, to the writeback stage.
- One transaction outstanding at a time; sequenced by an FSM.

Parameters:
- TIMEOUT_CYCLES, 255: cycles spent in REQ+WAIT before the transaction is abandoned with a fault. Must be ≥1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  execute stage presents an operation.
- req_ready  out  1  LSU can accept an operation.
- req_load  in  1  operation is a load.
- req_store  in  1  operation is a store. req_load and req_store are never both 1.
- req_funct3  in  3  RV32I load/store funct3.
- req_addr  in  32  effective address (ALU result).
- req_wdata  in  32  store data (rs2).
- req_rd  in  5  load destination register.
- mem_req  out  1  bus request.
- mem_we  out  1  1=write.
- mem_addr  out  32  word address, bits[1:0]=0.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated write data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and faults.
- resp_rd  out  5  captured req_rd; 0 for stores.
- resp_misaligned  out  1  alignment fault, qualified by resp_valid.
- resp_fault  out  1  illegal funct3 or timeout, qualified by resp_valid.
- busy  out  1  state ≠ IDLE.

Behaviour:
- Reset (async, immediate):
  - State = IDLE; all outputs 0 except req_ready=1.
  - Reset asserted mid-transaction drops mem_req at once. No response is ever produced for the aborted operation.
- States:
  - IDLE: req_ready=1.
  - REQ: mem_req=1. Address, byte enables and write data held stable until mem_gnt.
  - WAIT: load data outstanding.
  - DONE: resp_valid=1 for exactly one cycle, then IDLE.
- Accept:
  - An operation is accepted when req_valid & req_ready & (req_load | req_store). All request fields are registered at that edge.
  - req_valid with neither req_load nor req_store is ignored.
- Checks at accept, in priority order:
  1. funct3 ∈ {011, 110, 111}, or a store with funct3[2]=1 → DONE, resp_fault=1.
  2. Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0 → DONE, resp_misaligned=1.
  - Neither fault case issues a bus access.
- Otherwise → REQ:
  - mem_addr = {addr[31:2], 2'b00}.
  - Byte: be = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - Half: be = 4'b0011 << addr[1:0]; wdata = {2{wdata[15:0]}}.
  - Word: be = 4'b1111.
  - mem_we = store. For loads, mem_be carries the same lanes and mem_wdata = 0.
- REQ + mem_gnt:
  - Store → DONE.
  - Load → WAIT. An mem_rvalid in the same cycle as mem_gnt is not sampled; rvalid is valid only from the following cycle.
- WAIT + mem_rvalid:
  - Shift mem_rdata right by 8*addr[1:0], then extend: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
  - Result registered into resp_rdata → DONE.
- Timeout:
  - Counter clears on accept and increments each cycle in REQ or WAIT.
  - On reaching TIMEOUT_CYCLES without the awaited event → DONE, resp_fault=1, mem_req dropped.
  - A late mem_gnt or mem_rvalid arriving in IDLE or DONE is ignored.
- Response fields hold their values until the next DONE; they are qualified only by resp_valid.
- Latency, with gnt in the first REQ cycle:
  - Load: accept at T0, REQ T1, WAIT T2 (rvalid), resp_valid at T3.
  - Store: resp_valid at T2.
  - Fault: resp_valid at T1.
- Back-to-back: req_ready=0 from the cycle after accept through DONE. The next accept can occur in the cycle after DONE.

Test Plan:
- LB at addr 0x103, mem_rdata=0x80_00_00_00, gnt immediate, rvalid next cycle → mem_addr=0x100, be=1000, resp_rdata=0xFFFFFF80, resp_valid at T3.
- LHU at 0x102, rdata=0xBEEF1234 → be=1100, resp_rdata=0x0000BEEF.
- SH at 0x202, wdata=0x1234ABCD, gnt held low 3 cycles → mem_req/addr/be/wdata stable all 3 cycles; be=1100, wdata=0xABCDABCD, resp_valid 1 cycle after gnt.
- LW at 0x105 → no mem_req, resp_valid at T1, resp_misaligned=1, resp_rdata=0. funct3=011 → resp_fault=1.
- TIMEOUT_CYCLES=4, gnt never asserted → mem_req high 4 cycles, then resp_valid with resp_fault=1; a later stray rvalid produces no response.
- Assert rst during WAIT → mem_req/busy/resp_valid low immediately, req_ready=1; next LW at 0x0 completes normally.
